// File: rtl/instr_fetch.sv
// instr_fetch: PC holder that reads a synchronous instruction memory and hands words to the CU over valid/ready
module instr_fetch #(
    parameter int              ADDR_W   = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               halted
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALTED} state_t;
    state_t state, next;
    logic [ADDR_W-1:0] pc;
    logic halt_pend;
    // state, pc and captured instruction; a branch discards any returning read
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            halt_pend <= 1'b0;
            instr     <= '0;
            instr_pc  <= '0;
        end else begin
            state <= next;
            if (branch_en) begin
                pc        <= branch_target;
                halt_pend <= 1'b0;
            end else if (state == S_WAIT) begin
                instr     <= mem_rdata;
                instr_pc  <= pc;
                pc        <= pc + ADDR_W'(1);
                halt_pend <= mem_rdata[INSTR_W-1 -: 4] == HALT_OP;
            end
        end
    end
    // next state: redirect overrides everything, HOLD waits for the CU
    always_comb begin
        next = state;
        case (state)
            S_REQ:    next = S_WAIT;
            S_WAIT:   next = S_HOLD;
            S_HOLD:   next = instr_ready ? (halt_pend ? S_HALTED : S_REQ) : S_HOLD;
            default:  next = S_HALTED;
        endcase
        if (branch_en) next = S_REQ;
    end
    // outputs decoded from state; the read strobe is suppressed while in reset
    always_comb begin
        mem_rd      = state == S_REQ && !rst;
        mem_addr    = pc;
        instr_valid = state == S_HOLD;
        halted      = state == S_HALTED;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table plus hand sequences for halt, wrap and mid-fetch reset
module tb_instr_fetch;
    logic clk = 0;
    always #5 clk = ~clk;

    logic rst = 1, ready = 1, br = 0;
    logic [7:0] tgt = 0;
    logic mem_rd, valid, halted;
    logic [7:0] mem_addr, ipc;
    logic [15:0] rdata, instr;

    logic rst2 = 1, ready2 = 1, br2 = 0;
    logic [7:0] tgt2 = 0;
    logic mem_rd2, valid2, halted2;
    logic [7:0] mem_addr2, ipc2;
    logic [15:0] rdata2, instr2;

    logic [15:0] mem [256];

    instr_fetch dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(rdata),
        .instr(instr), .instr_pc(ipc), .instr_valid(valid), .instr_ready(ready),
        .branch_en(br), .branch_target(tgt), .halted(halted)
    );

    instr_fetch #(.RESET_PC(8'hFE)) dut2 (
        .clk(clk), .rst(rst2), .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_rdata(rdata2),
        .instr(instr2), .instr_pc(ipc2), .instr_valid(valid2), .instr_ready(ready2),
        .branch_en(br2), .branch_target(tgt2), .halted(halted2)
    );

    always @(posedge clk) begin
        if (mem_rd) rdata <= mem[mem_addr];
        if (mem_rd2) rdata2 <= mem[mem_addr2];
    end

    typedef struct {
        logic r, rdy, b;
        logic [7:0] t;
        logic e_rd;
        logic [7:0] e_addr;
        logic e_val;
        logic [15:0] e_ins;
        logic [7:0] e_ipc;
        logic e_hlt;
    } vec_t;

    vec_t tbl[$];
    int errors = 0, checks = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic b, input logic [7:0] t);
        @(negedge clk);
        rst = r; ready = rdy; br = b; tgt = t;
        #1;
    endtask

    initial begin
        logic [7:0] wrap_exp [3];
        int n;
        bit seen;
        foreach (mem[i]) mem[i] = 16'h0000;
        mem[0] = 16'h1000; mem[1] = 16'h2001; mem[2] = 16'h3002; mem[3] = 16'h4003;
        mem[4] = 16'h5004; mem[5] = 16'h6005; mem[8'h40] = 16'h7040; mem[8'h80] = 16'h8080;
        mem[8'hFE] = 16'hA0FE; mem[8'hFF] = 16'hB0FF;
        wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00;

        tbl.push_back('{1,1,0,8'h00, 0,8'h00,0,16'h0000,8'h00,0});
        tbl.push_back('{0,1,0,8'h00, 1,8'h00,0,16'h0000,8'h00,0});
        tbl.push_back('{0,1,0,8'h00, 0,8'h00,0,16'h0000,8'h00,0});
        tbl.push_back('{0,1,0,8'h00, 0,8'h01,1,16'h1000,8'h00,0});
        tbl.push_back('{0,1,0,8'h00, 1,8'h01,0,16'h1000,8'h00,0});
        tbl.push_back('{0,0,0,8'h00, 0,8'h01,0,16'h1000,8'h00,0});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{0,0,0,8'h00, 0,8'h02,1,16'h2001,8'h01,0});
        tbl.push_back('{0,1,0,8'h00, 0,8'h02,1,16'h2001,8'h01,0});
        tbl.push_back('{0,1,0,8'h00, 1,8'h02,0,16'h2001,8'h01,0});
        tbl.push_back('{0,1,0,8'h00, 0,8'h02,0,16'h2001,8'h01,0});
        tbl.push_back('{0,1,0,8'h00, 0,8'h03,1,16'h3002,8'h02,0});
        tbl.push_back('{0,1,0,8'h00, 1,8'h03,0,16'h3002,8'h02,0});
        tbl.push_back('{0,1,0,8'h00, 0,8'h03,0,16'h3002,8'h02,0});
        tbl.push_back('{0,1,0,8'h00, 0,8'h04,1,16'h4003,8'h03,0});
        tbl.push_back('{0,1,0,8'h00, 1,8'h04,0,16'h4003,8'h03,0});
        tbl.push_back('{0,1,0,8'h00, 0,8'h04,0,16'h4003,8'h03,0});
        tbl.push_back('{0,1,0,8'h00, 0,8'h05,1,16'h5004,8'h04,0});
        tbl.push_back('{0,1,0,8'h00, 1,8'h05,0,16'h5004,8'h04,0});
        tbl.push_back('{0,1,1,8'h40, 0,8'h05,0,16'h5004,8'h04,0});
        tbl.push_back('{0,1,0,8'h00, 1,8'h40,0,16'h5004,8'h04,0});
        tbl.push_back('{0,1,0,8'h00, 0,8'h40,0,16'h5004,8'h04,0});
        tbl.push_back('{0,1,1,8'h80, 0,8'h41,1,16'h7040,8'h40,0});
        tbl.push_back('{0,1,0,8'h00, 1,8'h80,0,16'h7040,8'h40,0});
        tbl.push_back('{0,1,0,8'h00, 0,8'h80,0,16'h7040,8'h40,0});
        tbl.push_back('{0,1,0,8'h00, 0,8'h81,1,16'h8080,8'h80,0});

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].rdy, tbl[i].b, tbl[i].t);
            chk($sformatf("v%0d mem_rd", i), mem_rd, tbl[i].e_rd);
            chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d valid", i), valid, tbl[i].e_val);
            chk($sformatf("v%0d instr", i), instr, tbl[i].e_ins);
            chk($sformatf("v%0d instr_pc", i), ipc, tbl[i].e_ipc);
            chk($sformatf("v%0d halted", i), halted, tbl[i].e_hlt);
        end

        mem[2] = 16'hF000;
        cyc(1, 1, 0, 8'h00);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cyc(0, 1, 0, 8'h00);
            if (valid && instr == 16'hF000) seen = 1;
        end
        chk("halt delivered", seen, 1);
        chk("halt instr_pc", ipc, 8'h02);
        chk("halt not yet halted", halted, 0);
        for (int k = 0; k < 20; k++) begin
            cyc(0, 1, 0, 8'h00);
            chk($sformatf("halted h%0d", k), halted, 1);
            chk($sformatf("halted mem_rd h%0d", k), mem_rd, 0);
        end
        cyc(0, 1, 1, 8'h10);
        cyc(0, 1, 0, 8'h00);
        chk("resume halted", halted, 0);
        chk("resume mem_rd", mem_rd, 1);
        chk("resume mem_addr", mem_addr, 8'h10);

        rst2 = 0;
        n = 0;
        for (int k = 0; k < 30 && n < 3; k++) begin
            cyc(0, 1, 0, 8'h00);
            if (valid2) begin
                chk($sformatf("wrap pc%0d", n), ipc2, wrap_exp[n]);
                n++;
            end
        end
        chk("wrap count", n, 3);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cyc(0, 1, 0, 8'h00);
            seen = mem_rd2;
        end
        chk("wrap req seen", seen, 1);
        cyc(0, 1, 0, 8'h00);
        chk("wait cycle mem_rd", mem_rd2, 0);
        chk("wait cycle valid", valid2, 0);
        rst2 = 1;
        cyc(0, 1, 0, 8'h00);
        chk("in rst mem_rd", mem_rd2, 0);
        rst2 = 0;
        #1;
        chk("post rst valid", valid2, 0);
        chk("post rst halted", halted2, 0);
        chk("post rst mem_rd", mem_rd2, 1);
        chk("post rst mem_addr", mem_addr2, 8'hFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
